qar_dmem_arbiter: RTL and testbench

Two-master arbiter that shares the single external data-memory port of the QAR-Core system (valid/we/addr/wdata/ready/rdata) between the core load/store unit (master 0) and a peripheral DMA master such as the CAN RX mailbox copier (master 1). Grants are round-robin with one outstanding transfer at a time. Request fields are latched at grant, so the memory side sees stable registered signals. A bus watchdog completes a stalled transfer with an error so that neither master hangs forever.

---
 rtl/qar_dmem_arbiter.sv | 133 +++++++++++++
 tb/tb_qar_dmem_arbiter.sv | 359 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/qar_dmem_arbiter.sv
// qar_dmem_arbiter: round-robin two-master arbiter for the shared data-memory port.
// Request fields are latched at grant; a watchdog terminates stalled transfers with an error.
module qar_dmem_arbiter #(
    parameter int unsigned ADDR_WIDTH     = 32,
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  m0_valid,
    input  logic                  m0_we,
    input  logic [ADDR_WIDTH-1:0] m0_addr,
    input  logic [DATA_WIDTH-1:0] m0_wdata,
    output logic                  m0_ready,
    output logic [DATA_WIDTH-1:0] m0_rdata,
    output logic                  m0_err,
    input  logic                  m1_valid,
    input  logic                  m1_we,
    input  logic [ADDR_WIDTH-1:0] m1_addr,
    input  logic [DATA_WIDTH-1:0] m1_wdata,
    output logic                  m1_ready,
    output logic [DATA_WIDTH-1:0] m1_rdata,
    output logic                  m1_err,
    output logic                  mem_valid,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic                  mem_ready,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic                  grant,
    output logic                  busy
);

    localparam int unsigned          CNT_WIDTH = 16;
    localparam logic [CNT_WIDTH-1:0] CNT_LAST  = CNT_WIDTH'(TIMEOUT_CYCLES - 32'd1);
    localparam logic                 WDOG_EN   = (TIMEOUT_CYCLES != 32'd0);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t                state, state_nxt;
    logic                  last_grant, last_grant_nxt;
    logic                  grant_nxt;
    logic                  mem_we_nxt;
    logic [ADDR_WIDTH-1:0] mem_addr_nxt;
    logic [DATA_WIDTH-1:0] mem_wdata_nxt;
    logic [CNT_WIDTH-1:0]  wdog_cnt, wdog_cnt_nxt;

    logic sel_c;
    logic timeout_c;
    logic done_c;
    logic owner0_c;
    logic owner1_c;

    // Winner of an IDLE arbitration: the sole requester, or the one not served last on a tie
    assign sel_c = (m0_valid && m1_valid) ? ~last_grant : m1_valid;

    // Watchdog fires in the TIMEOUT_CYCLES-th stalled BUSY cycle; a real completion wins
    assign timeout_c = WDOG_EN && (state == BUSY) && !mem_ready && (wdog_cnt == CNT_LAST);
    assign done_c    = (state == BUSY) && (mem_ready || timeout_c);

    // Memory-side request and status come straight from the state register
    assign busy      = (state == BUSY);
    assign mem_valid = (state == BUSY);

    // Completion routing to the owning master; reset suppresses any completion
    assign owner0_c = !rst && (state == BUSY) && !grant;
    assign owner1_c = !rst && (state == BUSY) &&  grant;

    assign m0_ready = owner0_c && (mem_ready || timeout_c);
    assign m0_err   = owner0_c && timeout_c;
    assign m0_rdata = (owner0_c && !timeout_c) ? mem_rdata : '0;

    assign m1_ready = owner1_c && (mem_ready || timeout_c);
    assign m1_err   = owner1_c && timeout_c;
    assign m1_rdata = (owner1_c && !timeout_c) ? mem_rdata : '0;

    // Next-state logic: grant and latch in IDLE, wait for completion or timeout in BUSY
    always_comb begin
        state_nxt      = state;
        grant_nxt      = grant;
        last_grant_nxt = last_grant;
        mem_we_nxt     = mem_we;
        mem_addr_nxt   = mem_addr;
        mem_wdata_nxt  = mem_wdata;
        wdog_cnt_nxt   = wdog_cnt;
        case (state)
            IDLE: begin
                if (m0_valid || m1_valid) begin
                    grant_nxt      = sel_c;
                    last_grant_nxt = sel_c;
                    mem_we_nxt     = sel_c ? m1_we    : m0_we;
                    mem_addr_nxt   = sel_c ? m1_addr  : m0_addr;
                    mem_wdata_nxt  = sel_c ? m1_wdata : m0_wdata;
                    wdog_cnt_nxt   = '0;
                    state_nxt      = BUSY;
                end
            end
            BUSY: begin
                if (done_c) begin
                    state_nxt = IDLE;
                end else begin
                    wdog_cnt_nxt = wdog_cnt + CNT_WIDTH'(1);
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State and latched request registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            grant      <= 1'b0;
            last_grant <= 1'b1;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            wdog_cnt   <= '0;
        end else begin
            state      <= state_nxt;
            grant      <= grant_nxt;
            last_grant <= last_grant_nxt;
            mem_we     <= mem_we_nxt;
            mem_addr   <= mem_addr_nxt;
            mem_wdata  <= mem_wdata_nxt;
            wdog_cnt   <= wdog_cnt_nxt;
        end
    end

endmodule

// File: tb/tb_qar_dmem_arbiter.sv
// Bench for qar_dmem_arbiter: behavioural memory with wait/stall control and per-master scoreboards.
module tb_qar_dmem_arbiter;

    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
    localparam int unsigned TO = 16;

    typedef struct packed {
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [DW-1:0] rdata;
        logic          chk;
        logic          err;
    } req_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          m0_valid, m0_we, m0_ready, m0_err;
    logic [AW-1:0] m0_addr;
    logic [DW-1:0] m0_wdata, m0_rdata;
    logic          m1_valid, m1_we, m1_ready, m1_err;
    logic [AW-1:0] m1_addr;
    logic [DW-1:0] m1_wdata, m1_rdata;
    logic          mem_valid, mem_we, mem_ready;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata, mem_rdata;
    logic          grant, busy;

    int n_tests = 0;
    int n_fail  = 0;

    req_t req0_q[$], req1_q[$], sb0[$], sb1[$];
    logic act0 = 1'b0, act1 = 1'b0;

    logic          s_r0, s_r1, s_e0, s_busy, s_grant, s_mv;
    logic [DW-1:0] s_rd0, s_wdata;
    logic [AW-1:0] s_addr;

    // Memory model
    logic [DW-1:0] mem_arr [0:63];
    logic          stall = 1'b0;
    int            wait_target = 0;
    int            wcnt = 0;

    qar_dmem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst(rst),
        .m0_valid(m0_valid), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_ready(m0_ready), .m0_rdata(m0_rdata), .m0_err(m0_err),
        .m1_valid(m1_valid), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_ready(m1_ready), .m1_rdata(m1_rdata), .m1_err(m1_err),
        .mem_valid(mem_valid), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ready(mem_ready), .mem_rdata(mem_rdata),
        .grant(grant), .busy(busy)
    );

    always #5 clk = ~clk;

    assign mem_ready = mem_valid && !stall && (wcnt >= wait_target);
    assign mem_rdata = mem_arr[mem_addr[7:2]];

    initial begin
        for (int i = 0; i < 64; i++) mem_arr[i] <= 32'hA500_0000 | 32'(i);
        mem_arr[3] <= 32'h0000_0321;
        mem_arr[5] <= 32'h0102_0304;
        mem_arr[8] <= 32'h8888_8888;
    end

    // Memory write port and wait-state counter
    always @(posedge clk) begin
        if (mem_valid && mem_ready && mem_we) mem_arr[mem_addr[7:2]] <= mem_wdata;
        if (!mem_valid || mem_ready) wcnt <= 0;
        else                         wcnt <= wcnt + 1;
    end

    initial begin
        #100000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    task automatic send(input int m, input logic we, input logic [AW-1:0] addr,
                        input logic [DW-1:0] wdata, input logic [DW-1:0] rdata, input logic err);
        req_t r;
        r.we = we; r.addr = addr; r.wdata = wdata; r.rdata = rdata;
        r.err = err; r.chk = !we || err;
        if (m == 0) req0_q.push_back(r);
        else        req1_q.push_back(r);
    endtask

    // Present the next queued request of any idle master and record its expected completion
    task automatic load_pending();
        req_t r;
        if (!act0) begin
            if (req0_q.size() != 0) begin
                r = req0_q.pop_front();
                m0_valid = 1'b1; m0_we = r.we; m0_addr = r.addr; m0_wdata = r.wdata;
                sb0.push_back(r); act0 = 1'b1;
            end else m0_valid = 1'b0;
        end
        if (!act1) begin
            if (req1_q.size() != 0) begin
                r = req1_q.pop_front();
                m1_valid = 1'b1; m1_we = r.we; m1_addr = r.addr; m1_wdata = r.wdata;
                sb1.push_back(r); act1 = 1'b1;
            end else m1_valid = 1'b0;
        end
    endtask

    // One clock: sample at negedge, retire completions against the scoreboards, then drive
    task automatic step();
        req_t e;
        @(negedge clk);
        s_r0 = m0_ready; s_r1 = m1_ready; s_e0 = m0_err; s_rd0 = m0_rdata;
        s_busy = busy; s_grant = grant; s_mv = mem_valid; s_addr = mem_addr; s_wdata = mem_wdata;
        if (m0_ready) begin
            n_tests++;
            if (sb0.size() == 0) begin
                n_fail++; $display("FAIL sb_m0: m0_ready=1 with no request outstanding");
            end else begin
                e = sb0.pop_front();
                if (m0_err !== e.err || (e.chk && m0_rdata !== e.rdata) || m1_ready !== 1'b0 ||
                    m1_err !== 1'b0 || m1_rdata !== '0) begin
                    n_fail++;
                    $display("FAIL sb_m0: got err=%b rdata=%h m1_ready=%b m1_err=%b m1_rdata=%h, want err=%b rdata=%h m1 all 0",
                             m0_err, m0_rdata, m1_ready, m1_err, m1_rdata, e.err, e.rdata);
                end
            end
        end
        if (m1_ready) begin
            n_tests++;
            if (sb1.size() == 0) begin
                n_fail++; $display("FAIL sb_m1: m1_ready=1 with no request outstanding");
            end else begin
                e = sb1.pop_front();
                if (m1_err !== e.err || (e.chk && m1_rdata !== e.rdata) || m0_ready !== 1'b0 ||
                    m0_err !== 1'b0 || m0_rdata !== '0) begin
                    n_fail++;
                    $display("FAIL sb_m1: got err=%b rdata=%h m0_ready=%b m0_err=%b m0_rdata=%h, want err=%b rdata=%h m0 all 0",
                             m1_err, m1_rdata, m0_ready, m0_err, m0_rdata, e.err, e.rdata);
                end
            end
        end
        @(posedge clk); #1;
        if (s_r0) act0 = 1'b0;
        if (s_r1) act1 = 1'b0;
        load_pending();
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_tests++;
        if ({mem_valid, mem_we, busy, grant, m0_ready, m1_ready, m0_err, m1_err} !== 8'h00 ||
            mem_addr !== '0 || mem_wdata !== '0 || m0_rdata !== '0 || m1_rdata !== '0) begin
            n_fail++;
            $display("FAIL reset_values: valid=%b we=%b busy=%b grant=%b rdy=%b%b err=%b%b addr=%h wdata=%h, want all 0",
                     mem_valid, mem_we, busy, grant, m0_ready, m1_ready, m0_err, m1_err, mem_addr, mem_wdata);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_tie_after_reset();
        int i0 = -1, i1 = -1;
        logic g0 = 1'bx, g1 = 1'bx;
        send(0, 1'b1, 32'h00, 32'h0000_0123, '0, 1'b0);
        send(1, 1'b1, 32'h04, 32'hDEAD_BEEF, '0, 1'b0);
        rst = 1'b0;
        load_pending();
        for (int c = 0; c < 6; c++) begin
            step();
            if (s_r0 && i0 < 0) begin i0 = c; g0 = s_grant; end
            if (s_r1 && i1 < 0) begin i1 = c; g1 = s_grant; end
        end
        n_tests++;
        if (i0 != 1 || g0 !== 1'b0) begin
            n_fail++; $display("FAIL tie_m0_first: m0 done cycle %0d grant %b, want cycle 1 grant 0", i0, g0);
        end
        n_tests++;
        if (i1 != 3 || g1 !== 1'b1) begin
            n_fail++; $display("FAIL tie_m1_second: m1 done cycle %0d grant %b, want cycle 3 grant 1", i1, g1);
        end
        n_tests++;
        if (mem_arr[0] !== 32'h0000_0123 || mem_arr[1] !== 32'hDEAD_BEEF) begin
            n_fail++; $display("FAIL tie_mem_words: got %h %h, want 00000123 deadbeef", mem_arr[0], mem_arr[1]);
        end
    endtask

    task automatic test_single_read();
        send(0, 1'b0, 32'h0C, '0, 32'h0000_0321, 1'b0);
        load_pending();
        step();
        n_tests++;
        if (s_busy !== 1'b0 || s_mv !== 1'b0) begin
            n_fail++; $display("FAIL single_idle: busy=%b mem_valid=%b, want 0 0", s_busy, s_mv);
        end
        step();
        n_tests++;
        if (s_mv !== 1'b1 || s_addr !== 32'h0C || s_r0 !== 1'b1 || s_rd0 !== 32'h0000_0321 || s_r1 !== 1'b0) begin
            n_fail++;
            $display("FAIL single_read: mem_valid=%b addr=%h m0_ready=%b m0_rdata=%h m1_ready=%b, want 1 0000000c 1 00000321 0",
                     s_mv, s_addr, s_r0, s_rd0, s_r1);
        end
        repeat (2) step();
    endtask

    task automatic test_wait_states();
        int nb1 = 0, pulses = 0, ir1 = -1, ig0 = -1;
        logic stable = 1'b1;
        wait_target = 5;
        send(1, 1'b1, 32'h10, 32'hCAFE_BABE, '0, 1'b0);
        load_pending();
        step();
        send(0, 1'b0, 32'h18, '0, 32'hA500_0006, 1'b0);
        for (int c = 1; c < 20; c++) begin
            step();
            if (s_busy && s_grant) begin
                nb1++;
                if (s_mv !== 1'b1 || s_addr !== 32'h10 || s_wdata !== 32'hCAFE_BABE) stable = 1'b0;
            end
            if (s_r1) begin pulses++; ir1 = c; end
            if (s_busy && !s_grant && ig0 < 0) ig0 = c;
        end
        wait_target = 0;
        n_tests++;
        if (nb1 != 6 || stable !== 1'b1) begin
            n_fail++; $display("FAIL wait_stable: busy cycles %0d stable %b, want 6 1", nb1, stable);
        end
        n_tests++;
        if (pulses != 1) begin
            n_fail++; $display("FAIL wait_pulse: m1_ready pulses %0d, want 1", pulses);
        end
        n_tests++;
        if (ir1 < 0 || ig0 != ir1 + 2) begin
            n_fail++; $display("FAIL wait_next_grant: m0 busy at cycle %0d, want %0d", ig0, ir1 + 2);
        end
        n_tests++;
        if (mem_arr[4] !== 32'hCAFE_BABE) begin
            n_fail++; $display("FAIL wait_mem_word: got %h, want cafebabe", mem_arr[4]);
        end
    endtask

    task automatic test_timeout();
        int bc = 0, hit = -1, after = -10;
        logic herr = 1'b0, mv_after = 1'bx;
        logic [DW-1:0] hrd = 'x;
        stall = 1'b1;
        send(0, 1'b0, 32'h1C, '0, '0, 1'b1);
        load_pending();
        for (int c = 0; c < 30; c++) begin
            step();
            if (s_busy && hit < 0) bc++;
            if (s_r0 && hit < 0) begin hit = bc; herr = s_e0; hrd = s_rd0; after = c; end
            if (c == after + 1) mv_after = s_mv;
        end
        stall = 1'b0;
        n_tests++;
        if (hit != int'(TO) || herr !== 1'b1 || hrd !== '0) begin
            n_fail++; $display("FAIL timeout_err: ready at busy cycle %0d err=%b rdata=%h, want 16 1 0", hit, herr, hrd);
        end
        n_tests++;
        if (mv_after !== 1'b0) begin
            n_fail++; $display("FAIL timeout_release: mem_valid=%b after error, want 0", mv_after);
        end
        send(1, 1'b0, 32'h14, '0, 32'h0102_0304, 1'b0);
        repeat (5) step();
    endtask

    task automatic test_back_to_back();
        logic [7:0] seq = '0;
        int n = 0, n0 = 0, n1 = 0;
        logic prev_busy = 1'b0, b2b = 1'b0;
        for (int i = 0; i < 4; i++) begin
            send(0, 1'b0, 32'h80 + 32'(4 * i), '0, 32'hA500_0020 + 32'(i), 1'b0);
            send(1, 1'b0, 32'hC0 + 32'(4 * i), '0, 32'hA500_0030 + 32'(i), 1'b0);
        end
        load_pending();
        for (int c = 0; c < 24; c++) begin
            step();
            if (prev_busy && s_busy) b2b = 1'b1;
            prev_busy = s_busy;
            if ((s_r0 || s_r1) && n < 8) begin seq[n] = s_grant; n++; end
            if (s_r0) n0++;
            if (s_r1) n1++;
        end
        n_tests++;
        if (n != 8 || seq !== 8'hAA) begin
            n_fail++; $display("FAIL b2b_sequence: %0d grants seq(lsb first)=%b, want 8 10101010", n, seq);
        end
        n_tests++;
        if (n0 != 4 || n1 != 4 || b2b !== 1'b0) begin
            n_fail++; $display("FAIL b2b_balance: m0=%0d m1=%0d busy_to_busy=%b, want 4 4 0", n0, n1, b2b);
        end
    endtask

    task automatic test_reset_mid();
        int first = -1;
        stall = 1'b1;
        send(0, 1'b1, 32'h20, 32'h5555_AAAA, '0, 1'b0);
        load_pending();
        repeat (4) step();
        rst = 1'b1;
        @(negedge clk);
        n_tests++;
        if (m0_ready !== 1'b0 || m0_err !== 1'b0) begin
            n_fail++; $display("FAIL rst_no_ready: m0_ready=%b m0_err=%b during reset, want 0 0", m0_ready, m0_err);
        end
        @(posedge clk); #1;
        rst = 1'b0; stall = 1'b0;
        m0_valid = 1'b0; act0 = 1'b0;
        req0_q.delete(); sb0.delete();
        @(negedge clk);
        n_tests++;
        if ({mem_valid, mem_we, busy, grant, m0_ready, m0_err} !== 6'b0 || mem_addr !== '0 || mem_wdata !== '0) begin
            n_fail++;
            $display("FAIL rst_mid_values: valid=%b we=%b busy=%b grant=%b ready=%b err=%b addr=%h wdata=%h, want all 0",
                     mem_valid, mem_we, busy, grant, m0_ready, m0_err, mem_addr, mem_wdata);
        end
        n_tests++;
        if (mem_arr[8] !== 32'h8888_8888) begin
            n_fail++; $display("FAIL rst_mem_word: got %h, want 88888888", mem_arr[8]);
        end
        @(posedge clk); #1;
        send(0, 1'b0, 32'h24, '0, 32'hA500_0009, 1'b0);
        send(1, 1'b0, 32'h28, '0, 32'hA500_000A, 1'b0);
        load_pending();
        for (int c = 0; c < 8; c++) begin
            step();
            if (first < 0 && s_r0) first = 0;
            if (first < 0 && s_r1) first = 1;
        end
        n_tests++;
        if (first != 0) begin
            n_fail++; $display("FAIL rst_first_tie: first served master %0d, want 0", first);
        end
    endtask

    initial begin
        rst = 1'b1;
        m0_valid = 1'b0; m0_we = 1'b0; m0_addr = '0; m0_wdata = '0;
        m1_valid = 1'b0; m1_we = 1'b0; m1_addr = '0; m1_wdata = '0;
        test_reset();
        test_tie_after_reset();
        test_single_read();
        test_wait_states();
        test_timeout();
        test_back_to_back();
        test_reset_mid();
        n_tests++;
        if (sb0.size() != 0 || sb1.size() != 0 || req0_q.size() != 0 || req1_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: outstanding m0=%0d m1=%0d queued m0=%0d m1=%0d, want all 0",
                     sb0.size(), sb1.size(), req0_q.size(), req1_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
